divider: RTL

Sequential restoring divider producing a 2*WIDTH-bit quotient and WIDTH-bit remainder from a 2*WIDTH-bit dividend and WIDTH-bit divisor, one quotient bit per cycle. It is the inverse of the key-generation multiplier and uses the same valid/busy handshake. Key generation uses it for modular reduction and for checking products, e.g. (p*q) mod e and n / p. It is area-minimal and not throughput-critical.

---
 rtl/divider.sv | 132 +++++++++++++
 1 files changed

// File: rtl/divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per cycle, behind a valid/busy handshake.
module divider #(
  parameter int WIDTH = 256
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [2*WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0]   divisor_in,
  input  logic               valid_in,
  output logic [2*WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0]   remainder_out,
  output logic               valid_out,
  output logic               busy_out,
  output logic               div_by_zero_out
);

  localparam int CW = $clog2(2*WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(2*WIDTH - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, COMPUTING, DONE} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] shiftReg_q, shiftReg_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [WIDTH-1:0]   partRem_q, partRem_d;
  logic [CW-1:0]      bitCount_q, bitCount_d;
  logic [2*WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               divZero_q, divZero_d;

  logic [WIDTH:0]     remShift;
  logic               remGe;
  logic [WIDTH-1:0]   remNext;
  logic [2*WIDTH-1:0] quotNext;

  // The held remainder is always below the divisor, so only the shifted value
  // needs the extra bit; a taken subtract always lands back inside WIDTH bits.
  always_comb begin
    remShift = {partRem_q, shiftReg_q[2*WIDTH-1]};
    remGe    = (remShift >= {1'b0, divisor_q});
    remNext  = remGe ? (remShift[WIDTH-1:0] - divisor_q) : remShift[WIDTH-1:0];
    quotNext = {shiftReg_q[2*WIDTH-2:0], remGe};
  end

  always_comb begin
    state_d     = state_q;
    shiftReg_d  = shiftReg_q;
    divisor_d   = divisor_q;
    partRem_d   = partRem_q;
    bitCount_d  = bitCount_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    valid_d     = 1'b0;
    busy_d      = busy_q;
    divZero_d   = divZero_q;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          shiftReg_d = dividend_in;
          divisor_d  = divisor_in;
          partRem_d  = '0;
          bitCount_d = '0;
          busy_d     = 1'b1;
          state_d    = (divisor_in == '0) ? DONE : COMPUTING;
        end
      end
      COMPUTING: begin
        shiftReg_d = quotNext;
        partRem_d  = remNext;
        bitCount_d = bitCount_q + ONE;
        if (bitCount_q == LAST_BIT) begin
          quotient_d  = quotNext;
          remainder_d = remNext;
          valid_d     = 1'b1;
          busy_d      = 1'b0;
          divZero_d   = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        // Still busy here only when a zero divisor skipped the iterations.
        if (busy_q) begin
          quotient_d  = '1;
          remainder_d = shiftReg_q[WIDTH-1:0];
          divZero_d   = 1'b1;
          valid_d     = 1'b1;
          busy_d      = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      shiftReg_q  <= '0;
      divisor_q   <= '0;
      partRem_q   <= '0;
      bitCount_q  <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      divZero_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shiftReg_q  <= shiftReg_d;
      divisor_q   <= divisor_d;
      partRem_q   <= partRem_d;
      bitCount_q  <= bitCount_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      divZero_q   <= divZero_d;
    end
  end

  assign quotient_out    = quotient_q;
  assign remainder_out   = remainder_q;
  assign valid_out       = valid_q;
  assign busy_out        = busy_q;
  assign div_by_zero_out = divZero_q;

endmodule
